// File: rtl/mips_wb_sched.sv
// mips_wb_sched -- write-port scheduler and load scoreboard for the MIPS I
// register file.
//
// The single register-file write port (file_rd/file_we/file_d) is shared
// between the ALU writeback and out-of-band load returns. Priority is
// ALU > return buffer > direct return. Destinations of loads in flight are
// kept in a small FIFO, in issue order. A one-entry return buffer holds a
// return that loses the port to the ALU. Decode is stalled while any of its
// registers is still owed a load write.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   alu_valid/rd/we/d    ALU writeback request
//   ld_issue, ld_rd      load issue (push destination), ld_issue_rdy = not full
//   ld_ret_valid/we/d    load return data (in issue order), ld_ret_rdy = accepted
//   dec_rs/rt/wd         decode registers checked for hazards, stall out
//   file_rd/we/d         register-file write port (write lands on next edge)
//
// Optional feature: define MIPS_WB_BYPASS_EN to add fwd_s_v, fwd_t_v and
// fwd_d. These forward a full-word write of this cycle straight to decode
// instead of stalling.
module mips_wb_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [3:0]  alu_we,
  input  logic [31:0] alu_d,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_issue_rdy,
  input  logic        ld_ret_valid,
  input  logic [3:0]  ld_ret_we,
  input  logic [31:0] ld_ret_d,
  output logic        ld_ret_rdy,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_wd,
  output logic        stall,
  output logic [4:0]  file_rd,
  output logic [3:0]  file_we,
  output logic [31:0] file_d
`ifdef MIPS_WB_BYPASS_EN
  ,
  output logic        fwd_s_v,
  output logic        fwd_t_v,
  output logic [31:0] fwd_d
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    fifo_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          rb_valid_r;
  logic [4:0]    rb_rd_r;
  logic [3:0]    rb_we_r;
  logic [31:0]   rb_d_r;

  logic             alu_act_s;
  logic             ret_acc_s;
  logic             push_s;
  logic             sel_rb_s;
  logic             sel_ret_s;
  logic             rb_load_s;
  logic [DEPTH-1:0] ent_valid_s;
  logic [4:0]       port_rd_s;
  logic [3:0]       port_we_s;
  logic [31:0]      port_d_s;

  // Distance of slot a from slot b, modulo DEPTH.
  function automatic logic [AW-1:0] ofs(input logic [AW-1:0] a, input logic [AW-1:0] b);
    ofs = a - b;
  endfunction

  // True if r is a non-zero register still owed a load write by the masked
  // FIFO entries or by the return buffer.
  function automatic logic pend(input logic [4:0] r, input logic [DEPTH-1:0] mask,
                                input logic rbv);
    logic hit;
    hit = rbv & (rb_rd_r == r);
    for (int i = 0; i < DEPTH; i++) begin
      if (mask[i] && (fifo_r[i] == r)) hit = 1'b1;
      else hit = hit;
    end
    pend = hit & (r != 5'd0);
  endfunction

  // Mark the FIFO slots that currently hold an in-flight destination.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_s[i] = {1'b0, ofs(AW'(i), head_r)} < count_r;
    end
  end

  // Handshakes and write-port arbitration.
  // A push is accepted at full when a pop frees a slot on the same edge.
  always_comb begin
    alu_act_s    = alu_valid & (alu_we != 4'h0);
    ld_issue_rdy = (count_r != FULL);
    ld_ret_rdy   = (count_r != {CW{1'b0}}) & (~rb_valid_r | ~alu_act_s);
    ret_acc_s    = ld_ret_valid & ld_ret_rdy;
    push_s       = ld_issue & (ld_issue_rdy | ret_acc_s);
    sel_rb_s     = ~alu_act_s & rb_valid_r;
    sel_ret_s    = ~alu_act_s & ~rb_valid_r & ret_acc_s;
    rb_load_s    = ret_acc_s & (alu_act_s | rb_valid_r);
  end

  // Write-port source mux.
  always_comb begin
    port_rd_s = 5'd0;
    port_we_s = 4'h0;
    port_d_s  = 32'h0;
    if (alu_act_s) begin
      port_rd_s = alu_rd;
      port_we_s = alu_we;
      port_d_s  = alu_d;
    end else if (sel_rb_s) begin
      port_rd_s = rb_rd_r;
      port_we_s = rb_we_r;
      port_d_s  = rb_d_r;
    end else if (sel_ret_s) begin
      port_rd_s = fifo_r[head_r];
      port_we_s = ld_ret_we;
      port_d_s  = ld_ret_d;
    end else begin
      port_rd_s = 5'd0;
    end
  end

  // Drive the file port; r0 is never written and nothing leaves during reset.
  always_comb begin
    if (reset) begin
      file_rd = 5'd0;
      file_we = 4'h0;
      file_d  = 32'h0;
    end else begin
      file_rd = port_rd_s;
      file_we = (port_rd_s == 5'd0) ? 4'h0 : port_we_s;
      file_d  = port_d_s;
    end
  end

`ifdef MIPS_WB_BYPASS_EN
  logic [DEPTH-1:0] oth_mask_s;
  logic             oth_rb_s;

  // Forwarding: the entry being written this cycle no longer blocks its reader.
  always_comb begin
    oth_mask_s = ent_valid_s;
    if (sel_ret_s) oth_mask_s[head_r] = 1'b0;
    else oth_mask_s = ent_valid_s;
    oth_rb_s = rb_valid_r & ~sel_rb_s;
    fwd_s_v  = (file_we == 4'hF) & (file_rd == dec_rs) & ~pend(dec_rs, oth_mask_s, oth_rb_s);
    fwd_t_v  = (file_we == 4'hF) & (file_rd == dec_rt) & ~pend(dec_rt, oth_mask_s, oth_rb_s);
    fwd_d    = file_d;
    stall    = (pend(dec_rs, ent_valid_s, rb_valid_r) & ~fwd_s_v) |
               (pend(dec_rt, ent_valid_s, rb_valid_r) & ~fwd_t_v) |
               pend(dec_wd, ent_valid_s, rb_valid_r);
  end
`else
  // Decode hazard against every outstanding load destination.
  always_comb begin
    stall = pend(dec_rs, ent_valid_s, rb_valid_r) |
            pend(dec_rt, ent_valid_s, rb_valid_r) |
            pend(dec_wd, ent_valid_s, rb_valid_r);
  end
`endif

  // FIFO storage; contents are qualified by count_r, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s) fifo_r[tail_r] <= ld_rd;
  end

  // Pointers, occupancy and return buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      rb_valid_r <= 1'b0;
      rb_rd_r    <= 5'd0;
      rb_we_r    <= 4'h0;
      rb_d_r     <= 32'h0;
    end else begin
      if (push_s) tail_r <= tail_r + AW'(1);
      if (ret_acc_s) head_r <= head_r + AW'(1);
      count_r <= count_r + CW'(push_s) - CW'(ret_acc_s);
      if (rb_load_s) begin
        rb_valid_r <= 1'b1;
        rb_rd_r    <= fifo_r[head_r];
        rb_we_r    <= ld_ret_we;
        rb_d_r     <= ld_ret_d;
      end else if (sel_rb_s) begin
        rb_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_wb_sched.sv
// Testbench for mips_wb_sched: directed scenarios followed by random traffic.
// Each cycle is compared against a reference model built from a queue of
// pending load destinations and a held-return record.
module tb_mips_wb_sched;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [3:0]  alu_we;
  logic [31:0] alu_d;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_issue_rdy;
  logic        ld_ret_valid;
  logic [3:0]  ld_ret_we;
  logic [31:0] ld_ret_d;
  logic        ld_ret_rdy;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_wd;
  logic        stall;
  logic [4:0]  file_rd;
  logic [3:0]  file_we;
  logic [31:0] file_d;
`ifdef MIPS_WB_BYPASS_EN
  logic        fwd_s_v;
  logic        fwd_t_v;
  logic [31:0] fwd_d;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int          q[$];
  bit          m_rb_v;
  int          m_rb_rd;
  logic [3:0]  m_rb_we;
  logic [31:0] m_rb_d;

  mips_wb_sched #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_we(alu_we), .alu_d(alu_d),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_issue_rdy(ld_issue_rdy),
    .ld_ret_valid(ld_ret_valid), .ld_ret_we(ld_ret_we), .ld_ret_d(ld_ret_d),
    .ld_ret_rdy(ld_ret_rdy),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wd(dec_wd), .stall(stall),
    .file_rd(file_rd), .file_we(file_we), .file_d(file_d)
`ifdef MIPS_WB_BYPASS_EN
    , .fwd_s_v(fwd_s_v), .fwd_t_v(fwd_t_v), .fwd_d(fwd_d)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register r is owed a load write, optionally ignoring the queue head or held return.
  function automatic bit pend(input int r, input bit skip_head, input bit skip_rb);
    bit hit = 1'b0;
    if (r == 0) return 1'b0;
    foreach (q[i]) if (!(skip_head && i == 0) && q[i] == r) hit = 1'b1;
    if (m_rb_v && !skip_rb && m_rb_rd == r) hit = 1'b1;
    return hit;
  endfunction

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_we = 4'h0; alu_d = 32'h0;
    ld_issue = 1'b0; ld_rd = 5'd0;
    ld_ret_valid = 1'b0; ld_ret_we = 4'h0; ld_ret_d = 32'h0;
    dec_rs = 5'd0; dec_rt = 5'd0; dec_wd = 5'd0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit alu_act, exp_irdy, exp_rrdy, acc, push_ok, exp_stall;
    int src, prd, popped;
    logic [3:0] pwe, exp_we;
    logic [31:0] pd;
    @(negedge clock);
    if (reset) begin
      q.delete();
      m_rb_v = 1'b0;
    end
    alu_act  = alu_valid && (alu_we != 4'h0);
    exp_irdy = (q.size() != DEPTH);
    exp_rrdy = (q.size() != 0) && (!m_rb_v || !alu_act);
    acc      = ld_ret_valid && exp_rrdy;
    src = 0; prd = 0; pwe = 4'h0; pd = 32'h0;
    if (reset) src = 0;
    else if (alu_act) begin src = 1; prd = alu_rd; pwe = alu_we; pd = alu_d; end
    else if (m_rb_v) begin src = 2; prd = m_rb_rd; pwe = m_rb_we; pd = m_rb_d; end
    else if (acc) begin src = 3; prd = q[0]; pwe = ld_ret_we; pd = ld_ret_d; end
    exp_we = (src == 0 || prd == 0) ? 4'h0 : pwe;
    exp_stall = pend(dec_rs, 0, 0) || pend(dec_rt, 0, 0) || pend(dec_wd, 0, 0);
`ifdef MIPS_WB_BYPASS_EN
    begin
      bit fs, ft;
      fs = (exp_we == 4'hF) && (prd == dec_rs) && !pend(dec_rs, src == 3, src == 2);
      ft = (exp_we == 4'hF) && (prd == dec_rt) && !pend(dec_rt, src == 3, src == 2);
      exp_stall = (pend(dec_rs, 0, 0) && !fs) || (pend(dec_rt, 0, 0) && !ft) ||
                  pend(dec_wd, 0, 0);
      chk("fwd_s_v", fwd_s_v, fs);
      chk("fwd_t_v", fwd_t_v, ft);
      if (fs || ft) chk("fwd_d", fwd_d, pd);
    end
`endif
    chk("ld_issue_rdy", ld_issue_rdy, exp_irdy);
    chk("ld_ret_rdy", ld_ret_rdy, exp_rrdy);
    chk("stall", stall, exp_stall);
    chk("file_we", file_we, exp_we);
    if (exp_we != 4'h0 || reset) begin
      chk("file_rd", file_rd, prd);
      chk("file_d", file_d, pd);
    end
    if (!reset) begin
      push_ok = ld_issue && (exp_irdy || acc);
      if (src == 2) m_rb_v = 1'b0;
      if (acc) begin
        popped = q.pop_front();
        if (src != 3) begin
          m_rb_v = 1'b1; m_rb_rd = popped; m_rb_we = ld_ret_we; m_rb_d = ld_ret_d;
        end
      end
      if (push_ok) q.push_back(int'(ld_rd));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_rb_v = 1'b0;
    #1;
    cycle(); cycle();
    reset = 1'b0;

    // Load r3 returns with the port free: written in the return cycle.
    ld_issue = 1'b1; ld_rd = 5'd3; cycle(); idle();
    ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'h11223344; cycle(); idle();

    // ALU and return collide: ALU wins, r7 follows from the held return.
    ld_issue = 1'b1; ld_rd = 5'd7; cycle(); idle();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_we = 4'hF; alu_d = 32'hA5A5_0002;
    ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'h0000_0777; cycle(); idle();
    cycle();

    // Stall on pending r9 via rt until its write, then clear; rs=0 never stalls.
    ld_issue = 1'b1; ld_rd = 5'd9; dec_rt = 5'd9; cycle();
    ld_issue = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'h9999_0009; cycle();
    ld_ret_valid = 1'b0; cycle(); idle(); cycle();

    // Fill the queue, then issue and return together at full.
    for (int i = 0; i < DEPTH; i++) begin
      ld_issue = 1'b1; ld_rd = 5'(10 + i); cycle();
    end
    idle();
    ld_issue = 1'b1; ld_rd = 5'd14;
    ld_ret_valid = 1'b1; ld_ret_we = 4'h3; ld_ret_d = 32'h0000_BEEF; cycle(); idle();
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'(i + 100); cycle();
    end
    idle(); cycle();

    // Load to r0: pops but never writes.
    ld_issue = 1'b1; ld_rd = 5'd0; cycle(); idle();
    ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'hFFFF_FFFF; cycle(); cycle(); idle();

    // Reset mid-load drops r5 without a write.
    ld_issue = 1'b1; ld_rd = 5'd5; dec_rs = 5'd5; cycle();
    ld_issue = 1'b0; cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; ld_ret_valid = 1'b1; ld_ret_we = 4'hF; ld_ret_d = 32'h5555_5555; cycle();
    idle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      alu_valid    = ($urandom_range(0, 2) == 0);
      alu_rd       = 5'($urandom_range(0, 12));
      alu_we       = 4'($urandom_range(0, 15));
      alu_d        = $urandom;
      ld_issue     = ($urandom_range(0, 2) == 0);
      ld_rd        = 5'($urandom_range(0, 12));
      ld_ret_valid = ($urandom_range(0, 1) == 0);
      ld_ret_we    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      ld_ret_d     = $urandom;
      dec_rs       = 5'($urandom_range(0, 12));
      dec_rt       = 5'($urandom_range(0, 12));
      dec_wd       = 5'($urandom_range(0, 12));
      reset        = ($urandom_range(0, 79) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
